// File: rtl/inst_fetch_pkg.sv
// Shared control encodings for the fetch stage: next-PC select codes,
// reset vector default and the fetch sequencer state type.
package inst_fetch_pkg;

    localparam logic [1:0]  NPC_PC_4         = 2'd0;
    localparam logic [1:0]  NPC_PC_IMM       = 2'd1;
    localparam logic [1:0]  NPC_RD1_IMM      = 2'd2;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam int          FETCH_ENTRY_W    = 64;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } fetch_state_e;

    function automatic logic is_redirect_op(input logic [1:0] op);
        return (op == NPC_PC_IMM) || (op == NPC_RD1_IMM);
    endfunction

    // jalr clears bit 0 of the computed target; branches/jal use the PC-relative sum
    function automatic logic [31:0] redirect_target(input logic [1:0]  op,
                                                    input logic [31:0] ex_pc,
                                                    input logic [31:0] imm,
                                                    input logic [31:0] rd1);
        if (op == NPC_RD1_IMM)
            return (rd1 + imm) & ~32'h1;
        return ex_pc + imm;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry in-order buffer between instruction memory and decode.
// The head reads as zero while empty so downstream sees a clean idle value.
module fetch_fifo #(
    parameter int DATA_W = 64
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_flush,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_pop,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_head,
    output logic [1:0]        o_count
);

    logic [DATA_W-1:0] r_mem [2];
    logic              r_rd;
    logic              r_wr;
    logic [1:0]        r_cnt;
    logic              w_push;
    logic              w_pop;

    assign w_pop  = i_pop && (r_cnt != 2'd0);
    assign w_push = i_push && ((r_cnt != 2'd2) || w_pop);

    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            r_rd  <= 1'b0;
            r_wr  <= 1'b0;
            r_cnt <= 2'd0;
        end else begin
            if (w_push) r_wr <= ~r_wr;
            if (w_pop)  r_rd <= ~r_rd;
            r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr] <= i_data;
    end

    assign o_valid = (r_cnt != 2'd0);
    assign o_head  = o_valid ? r_mem[r_rd] : '0;
    assign o_count = r_cnt;

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: issues word requests under a two-credit budget, buffers
// responses in a small FIFO and redirects on taken jumps/branches from execute.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        cpu_clk,
    input  logic        cpu_rst,
    input  logic        redirect,
    input  logic [1:0]  npc_op,
    input  logic [31:0] ex_pc,
    input  logic [31:0] imm,
    input  logic [31:0] rd1,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic [31:0] inst_pc4
);

    fetch_state_e             r_state;
    logic [31:0]              r_pc;
    logic [31:0]              r_req_pc;
    logic                     r_out;
    logic                     w_redir;
    logic [31:0]              w_target;
    logic                     w_fifo_valid;
    logic [FETCH_ENTRY_W-1:0] w_head;
    logic [1:0]               w_count;
    logic                     w_pop;
    logic [2:0]               w_credit_used;
    logic                     w_grant;
    logic                     w_rsp;
    logic                     w_push;
    logic                     w_out_next;

    assign w_redir  = redirect && is_redirect_op(npc_op);
    assign w_target = redirect_target(npc_op, ex_pc, imm, rd1);

    assign inst_valid = w_fifo_valid && !cpu_rst;
    assign w_pop      = inst_valid && inst_ready;

    // A pop this cycle frees a slot, which keeps fetch streaming at full rate
    assign w_credit_used = {1'b0, w_count} + {2'b00, r_out} - {2'b00, w_pop};
    assign imem_req  = !cpu_rst && (r_state == ST_RUN) && !redirect && (w_credit_used < 3'd2);
    assign imem_addr = r_pc;
    assign w_grant   = imem_req && imem_gnt;

    assign w_rsp      = imem_rvalid && r_out;
    assign w_push     = w_rsp && (r_state == ST_RUN) && !w_redir;
    assign w_out_next = w_grant || (r_out && !w_rsp);

    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            r_state <= ST_BOOT;
            r_pc    <= RESET_PC;
            r_out   <= 1'b0;
        end else begin
            if (w_redir)
                r_pc <= w_target;
            else if (w_grant)
                r_pc <= r_pc + 32'd4;
            case (r_state)
                ST_BOOT: begin
                    r_state <= ST_RUN;
                    r_out   <= 1'b0;
                end
                ST_RUN: begin
                    r_out <= w_out_next;
                    if (w_redir)
                        r_state <= w_out_next ? ST_FLUSH : ST_RUN;
                end
                ST_FLUSH: begin
                    r_out   <= 1'b0;
                    r_state <= ST_RUN;
                end
                default: begin
                    r_out   <= 1'b0;
                    r_state <= ST_RUN;
                end
            endcase
        end
    end

    always_ff @(posedge cpu_clk) begin
        if (w_grant) r_req_pc <= r_pc;
    end

    fetch_fifo #(.DATA_W(FETCH_ENTRY_W)) u_fifo (
        .i_clk   (cpu_clk),
        .i_rst   (cpu_rst),
        .i_flush (w_redir),
        .i_push  (w_push),
        .i_data  ({imem_rdata, r_req_pc}),
        .i_pop   (w_pop),
        .o_valid (w_fifo_valid),
        .o_head  (w_head),
        .o_count (w_count)
    );

    assign inst     = inst_valid ? w_head[63:32] : 32'h0;
    assign inst_pc  = inst_valid ? w_head[31:0]  : 32'h0;
    assign inst_pc4 = inst_pc + 32'd4;

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: directed corner sequences, a redirect
// target table, and a randomized run against a transaction-level model.
module tb_inst_fetch;

    logic        cpu_clk = 1'b0;
    logic        cpu_rst = 1'b1;
    logic        redirect = 1'b0;
    logic [1:0]  npc_op = 2'd0;
    logic [31:0] ex_pc = 32'h0;
    logic [31:0] imm = 32'h0;
    logic [31:0] rd1 = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [31:0] inst_pc4;

    int checks = 0;
    int errors = 0;

    always #5 cpu_clk = ~cpu_clk;

    inst_fetch dut (
        .cpu_clk     (cpu_clk),
        .cpu_rst     (cpu_rst),
        .redirect    (redirect),
        .npc_op      (npc_op),
        .ex_pc       (ex_pc),
        .imm         (imm),
        .rd1         (rd1),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .inst_valid  (inst_valid),
        .inst_ready  (inst_ready),
        .inst        (inst),
        .inst_pc     (inst_pc),
        .inst_pc4    (inst_pc4)
    );

    // Instruction memory contents: a fixed hash of the address
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'd2654435761) ^ 32'hC0DE_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Reference model: program-order fetch PC plus the queue of granted PCs
    // that decode is still owed, cleared by any effective redirect or reset.
    logic [31:0] exp_pc = 32'h0;
    logic [31:0] owed[$];
    logic        hold_vld = 1'b0;
    logic [31:0] hold_pc = 32'h0;
    logic [31:0] hold_inst = 32'h0;
    logic        spur_en = 1'b0;
    int          delivered = 0;

    task automatic settle();
        #1;
    endtask

    // Called after settle(): checks this cycle against the model, then moves
    // to the next negedge and plays the memory response.
    task automatic adv();
        logic        eff;
        logic [31:0] tgt;
        logic        g;
        logic [31:0] ga;
        g  = 1'b0;
        ga = 32'h0;
        if (cpu_rst) begin
            chk("req_in_reset", {31'b0, imem_req}, 32'h0);
            chk("valid_in_reset", {31'b0, inst_valid}, 32'h0);
            owed.delete();
            exp_pc   = 32'h0;
            hold_vld = 1'b0;
        end else begin
            eff = redirect && (npc_op == 2'd1 || npc_op == 2'd2);
            tgt = (npc_op == 2'd1) ? ex_pc + imm : (rd1 + imm) & 32'hFFFF_FFFE;
            if (hold_vld) begin
                chk("hold_valid", {31'b0, inst_valid}, 32'h1);
                chk("hold_pc", inst_pc, hold_pc);
                chk("hold_inst", inst, hold_inst);
            end
            if (inst_valid) begin
                if (owed.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid: got pc %h expected no instruction", inst_pc);
                end else begin
                    chk("head_pc", inst_pc, owed[0]);
                    chk("head_inst", inst, mem_word(owed[0]));
                    chk("head_pc4", inst_pc4, owed[0] + 32'd4);
                    if (inst_ready) begin
                        void'(owed.pop_front());
                        delivered++;
                    end
                end
            end
            hold_vld  = inst_valid && !inst_ready && !eff;
            hold_pc   = inst_pc;
            hold_inst = inst;
            if (redirect) chk("req_low_on_redirect", {31'b0, imem_req}, 32'h0);
            if (imem_req && imem_gnt) begin
                chk("fetch_addr", imem_addr, exp_pc);
                owed.push_back(exp_pc);
                exp_pc = exp_pc + 32'd4;
                g  = 1'b1;
                ga = imem_addr;
            end
            if (eff) begin
                owed.delete();
                exp_pc = tgt;
            end
        end
        @(posedge cpu_clk);
        @(negedge cpu_clk);
        imem_rvalid = g || (spur_en && $urandom_range(0, 9) == 0);
        imem_rdata  = g ? mem_word(ga) : $urandom();
    endtask

    // Two reset cycles, then the BOOT cycle with the given grant/ready levels.
    task automatic do_reset(input logic g, input logic r);
        cpu_rst = 1'b1; redirect = 1'b0; imem_gnt = 1'b0; inst_ready = 1'b0;
        settle(); adv();
        settle(); adv();
        cpu_rst = 1'b0; imem_gnt = g; inst_ready = r;
        settle();
        chk("boot_req", {31'b0, imem_req}, 32'h0);
        chk("boot_valid", {31'b0, inst_valid}, 32'h0);
        adv();
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [31:0] epc;
        logic [31:0] im;
        logic [31:0] r1;
        logic [31:0] exp_addr;
    } redir_vec_t;

    redir_vec_t vecs[7];

    initial begin
        vecs[0] = '{2'd1, 32'h0000_0010, 32'hFFFF_FFF8, 32'h0,         32'h0000_0008};
        vecs[1] = '{2'd2, 32'h0,         32'h0000_0002, 32'h0000_0101, 32'h0000_0102};
        vecs[2] = '{2'd2, 32'h0,         32'h0000_0000, 32'h0000_0103, 32'h0000_0102};
        vecs[3] = '{2'd2, 32'h0000_DEAD, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFE};
        vecs[4] = '{2'd0, 32'h0000_0100, 32'h0000_0020, 32'h0000_0300, 32'h0000_0000};
        vecs[5] = '{2'd3, 32'h0000_0100, 32'h0000_0020, 32'h0000_0300, 32'h0000_0000};
        vecs[6] = '{2'd1, 32'hFFFF_FFF0, 32'h0000_0020, 32'h0,         32'h0000_0010};

        @(negedge cpu_clk);

        // Reset values, then streaming start-up with memory and decode always ready
        cpu_rst = 1'b1;
        settle(); adv();
        settle();
        chk("rst_req", {31'b0, imem_req}, 32'h0);
        chk("rst_valid", {31'b0, inst_valid}, 32'h0);
        chk("rst_inst", inst, 32'h0);
        chk("rst_inst_pc", inst_pc, 32'h0);
        chk("rst_inst_pc4", inst_pc4, 32'h4);
        adv();
        cpu_rst = 1'b0; imem_gnt = 1'b1; inst_ready = 1'b1;
        settle();
        chk("boot_req", {31'b0, imem_req}, 32'h0);
        chk("boot_inst_pc4", inst_pc4, 32'h4);
        adv();
        settle();
        chk("c1_req", {31'b0, imem_req}, 32'h1);
        chk("c1_addr", imem_addr, 32'h0);
        chk("c1_valid", {31'b0, inst_valid}, 32'h0);
        adv();
        settle();
        chk("c2_addr", imem_addr, 32'h4);
        chk("c2_valid", {31'b0, inst_valid}, 32'h0);
        adv();
        settle();
        chk("c3_req", {31'b0, imem_req}, 32'h1);
        chk("c3_addr", imem_addr, 32'h8);
        chk("c3_valid", {31'b0, inst_valid}, 32'h1);
        chk("c3_inst_pc", inst_pc, 32'h0);
        chk("c3_inst_pc4", inst_pc4, 32'h4);
        chk("c3_inst", inst, mem_word(32'h0));
        adv();

        // Decode stalls: buffer fills, fetch stops, head holds at 0x0
        do_reset(1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin settle(); adv(); end
        settle();
        chk("stall_req", {31'b0, imem_req}, 32'h0);
        chk("stall_valid", {31'b0, inst_valid}, 32'h1);
        chk("stall_pc", inst_pc, 32'h0);
        adv();
        inst_ready = 1'b1;
        settle();
        chk("resume_req", {31'b0, imem_req}, 32'h1);
        chk("resume_addr", imem_addr, 32'h8);
        chk("resume_pc0", inst_pc, 32'h0);
        adv();
        settle();
        chk("resume_pc4", inst_pc, 32'h4);
        adv();
        settle();
        chk("resume_pc8", inst_pc, 32'h8);
        adv();

        // Redirect with a request in flight: stale 0x4 response is dropped
        do_reset(1'b1, 1'b1);
        settle(); adv();
        settle(); adv();
        redirect = 1'b1; npc_op = 2'd1; ex_pc = 32'h10; imm = 32'hFFFF_FFF8;
        settle();
        chk("flush_req_low", {31'b0, imem_req}, 32'h0);
        adv();
        redirect = 1'b0;
        settle();
        chk("flush_addr", imem_addr, 32'h8);
        chk("flush_req", {31'b0, imem_req}, 32'h1);
        chk("flush_valid0", {31'b0, inst_valid}, 32'h0);
        adv();
        settle();
        chk("flush_valid1", {31'b0, inst_valid}, 32'h0);
        adv();
        settle();
        chk("flush_first_pc", inst_pc, 32'h8);
        adv();

        // Back-to-back redirects: only the second target is fetched
        do_reset(1'b0, 1'b1);
        redirect = 1'b1; npc_op = 2'd1; ex_pc = 32'h0; imm = 32'h40;
        settle(); adv();
        imm = 32'h80;
        settle();
        chk("b2b_req_low", {31'b0, imem_req}, 32'h0);
        adv();
        redirect = 1'b0; imem_gnt = 1'b1;
        settle();
        chk("b2b_addr", imem_addr, 32'h80);
        adv();

        // PC wrap at the top of the address space
        do_reset(1'b0, 1'b1);
        redirect = 1'b1; npc_op = 2'd1; ex_pc = 32'h0; imm = 32'hFFFF_FFFC;
        settle(); adv();
        redirect = 1'b0; imem_gnt = 1'b1;
        settle();
        chk("wrap_addr_top", imem_addr, 32'hFFFF_FFFC);
        adv();
        settle();
        chk("wrap_addr_zero", imem_addr, 32'h0);
        adv();
        settle();
        chk("wrap_inst_pc", inst_pc, 32'hFFFF_FFFC);
        chk("wrap_inst_pc4", inst_pc4, 32'h0);
        adv();

        // Redirect target table
        for (int v = 0; v < 7; v++) begin
            do_reset(1'b0, 1'b1);
            redirect = 1'b1; npc_op = vecs[v].op; ex_pc = vecs[v].epc;
            imm = vecs[v].im; rd1 = vecs[v].r1;
            settle();
            chk($sformatf("tbl%0d_req_low", v), {31'b0, imem_req}, 32'h0);
            adv();
            redirect = 1'b0; imem_gnt = 1'b1;
            settle();
            chk($sformatf("tbl%0d_req", v), {31'b0, imem_req}, 32'h1);
            chk($sformatf("tbl%0d_addr", v), imem_addr, vecs[v].exp_addr);
            adv();
        end

        // Randomized traffic with redirects, stalls, stray responses and resets
        do_reset(1'b1, 1'b1);
        spur_en   = 1'b1;
        delivered = 0;
        for (int c = 0; c < 3000; c++) begin
            cpu_rst    = ($urandom_range(0, 299) == 0);
            imem_gnt   = ($urandom_range(0, 9) < 7);
            inst_ready = ($urandom_range(0, 9) < 7);
            redirect   = ($urandom_range(0, 19) == 0);
            npc_op     = 2'($urandom_range(0, 3));
            ex_pc      = $urandom() & 32'hFFFF_FFFC;
            imm        = 32'($urandom_range(0, 1023)) - 32'd512;
            rd1        = $urandom();
            settle();
            adv();
        end
        cpu_rst = 1'b0; redirect = 1'b0;
        spur_en = 1'b0;
        checks++;
        if (delivered < 300) begin
            errors++;
            $display("FAIL random_throughput: got %0d deliveries expected at least 300", delivered);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
